// File: rtl/sift_fifo_read_scheduler.sv
// sift_fifo_read_scheduler
//   Round-robin burst scheduler that lets NREQ requesters share one detection
//   FIFO. A requester is granted once the FIFO holds at least a full burst.
//   The granted requester then receives BURST_LEN words. Reads pause while the
//   FIFO is empty. A one-cycle DRAIN state lets the last word arrive, and
//   odone is pulsed during it.
// Ports
//   iclk, ireset   : clock, asynchronous active-high reset
//   ireq           : per-requester level request
//   iempty, iusedw : FIFO empty flag and fill level
//   ofifo_rdreq    : FIFO read strobe (BURST only)
//   ogrant         : registered one-hot grant, held through BURST and DRAIN
//   odata_valid    : FIFO q valid for the granted requester (1-cycle read latency)
//   odone          : end-of-burst pulse to the granted requester
//   obusy          : scheduler not idle
module sift_fifo_read_scheduler #(
  parameter int NREQ      = 4,
  parameter int BURST_LEN = 16,
  parameter int USEDW_W   = 15
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic [NREQ-1:0]    ireq,
  input  logic               iempty,
  input  logic [USEDW_W-1:0] iusedw,
  output logic               ofifo_rdreq,
  output logic [NREQ-1:0]    ogrant,
  output logic [NREQ-1:0]    odata_valid,
  output logic [NREQ-1:0]    odone,
  output logic               obusy
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t          state;
  logic [CW-1:0]   rd_cnt;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   win_idx;
  logic            win_vld;
  logic            start;
  logic            rdreq_q;

  // Round-robin search starting at rr_ptr. Walking the offsets from highest
  // to lowest lets the nearest asserted request overwrite the farther ones.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (ireq[(int'(rr_ptr) + i) % NREQ]) begin
        win_vld = 1'b1;
        win_idx = PW'((int'(rr_ptr) + i) % NREQ);
      end
    end
  end

  assign start = (state == IDLE) && win_vld && (32'(iusedw) >= 32'(BURST_LEN));

  // Gating on rd_cnt keeps the read strobe from exceeding the burst length.
  assign ofifo_rdreq = (state == BURST) && !iempty && (rd_cnt < CW'(BURST_LEN));

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state   <= IDLE;
      rd_cnt  <= '0;
      rr_ptr  <= '0;
      gidx    <= '0;
      ogrant  <= '0;
      rdreq_q <= 1'b0;
    end else begin
      rdreq_q <= ofifo_rdreq;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= BURST;
            rd_cnt <= '0;
            gidx   <= win_idx;
            ogrant <= NREQ'(1) << win_idx;
          end
        end
        BURST: begin
          if (ofifo_rdreq) begin
            rd_cnt <= rd_cnt + CW'(1);
            if (rd_cnt == CW'(BURST_LEN - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          state  <= IDLE;
          ogrant <= '0;
          rr_ptr <= (int'(gidx) == NREQ - 1) ? '0 : gidx + PW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign odata_valid = {NREQ{rdreq_q}} & ogrant;
  assign odone       = (state == DRAIN) ? ogrant : '0;
  assign obusy       = (state != IDLE);

endmodule

// File: doc/sift_fifo_read_scheduler.md
SIFT_FIFO_READ_SCHEDULER -- requirements
Module: sift_fifo_read_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of read requesters sharing one detection FIFO.
REQ-002 Parameter BURST_LEN, default 16: FIFO words per granted burst, range 1..255.
REQ-003 Parameter USEDW_W, default 15: width of the FIFO fill-level input.
REQ-004 iclk  in  1  single clock; all state is updated on its rising edge.
REQ-005 ireset  in  1  asynchronous, active-high reset.
REQ-006 ireq  in  NREQ  per-requester burst request, level-sensitive.
REQ-007 iempty  in  1  FIFO empty flag.
REQ-008 iusedw  in  USEDW_W  FIFO fill level.
REQ-009 ofifo_rdreq  out  1  FIFO read request, combinational from state.
REQ-010 ogrant  out  NREQ  registered one-hot grant; zero when no requester is served.
REQ-011 odata_valid  out  NREQ  one-hot flag marking FIFO q as valid for the granted requester.
REQ-012 odone  out  NREQ  one-cycle pulse to the granted requester at burst end.
REQ-013 obusy  out  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, BURST and DRAIN.
REQ-015 IDLE -> BURST SHALL occur when (ireq != 0) and (iusedw >= BURST_LEN); otherwise the FSM SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin.
  - Search order starts at index rr_ptr and wraps from NREQ-1 to 0.
  - The first asserted ireq in that order wins.
  - The winner is registered into ogrant on the IDLE -> BURST edge.
REQ-017 In BURST, ofifo_rdreq SHALL equal (!iempty) and (rd_cnt < BURST_LEN).
REQ-018 rd_cnt SHALL be a counter of width ceil(log2(BURST_LEN+1)).
  - Cleared to 0 on entry to BURST.
  - Incremented only in cycles where ofifo_rdreq is high.
REQ-019 If iempty is asserted mid-burst, ofifo_rdreq SHALL deassert, rd_cnt SHALL hold, and the burst SHALL resume when iempty clears, with no timeout.
REQ-020 BURST -> DRAIN SHALL occur on the edge where the rd_cnt increment reaches BURST_LEN.
REQ-021 DRAIN SHALL last exactly one cycle and then return to IDLE.
REQ-022 odata_valid SHALL be ofifo_rdreq registered once (1-cycle FIFO read latency), ANDed bitwise with ogrant.
REQ-023 odone SHALL equal ogrant during the DRAIN cycle and 0 in all other cycles.
REQ-024 ogrant SHALL remain constant through BURST and DRAIN and SHALL clear on DRAIN -> IDLE.
REQ-025 On DRAIN -> IDLE, rr_ptr SHALL become (granted index + 1) mod NREQ.
REQ-026 Once a burst is granted, ireq SHALL be ignored.
  - A deasserting or newly asserting ireq SHALL neither abort nor pre-empt the burst.
  - New requests are evaluated only in IDLE.
REQ-027 ofifo_rdreq SHALL be 0 in IDLE and DRAIN, so the block never reads an empty FIFO and never over-reads a burst.
REQ-028 Latency with no stalls: ireq accepted in cycle t gives:
  - ogrant and first rdreq at t+1;
  - last rdreq at t+BURST_LEN;
  - DRAIN, odone and last odata_valid at t+BURST_LEN+1;
  - next grant no earlier than t+BURST_LEN+3.

Reset
REQ-029 While ireset is high, the block SHALL hold:
  - state = IDLE, rd_cnt = 0, rr_ptr = 0;
  - ogrant = 0, odata_valid = 0, odone = 0, obusy = 0;
  - ofifo_rdreq = 0.
REQ-030 Reset asserted mid-burst SHALL abandon the burst immediately.
  - No odone is issued.
  - FIFO words already read are not replayed.
  - The first arbitration after release starts at index 0.

Verification
REQ-031 Single request: ireq=4'b0100, iusedw=20, iempty=0 -> ogrant=4'b0100 at t+1; 16 rdreq cycles; odone[2] pulse at t+17; rr_ptr=3.
REQ-032 Round-robin: ireq=4'b1111 held, iusedw>=16 throughout -> grants in order 0,1,2,3,0, each burst exactly 16 reads.
REQ-033 Insufficient data: ireq=4'b0001, iusedw=15 -> no grant and no rdreq; iusedw=16 next cycle -> grant on the following edge.
REQ-034 Empty stall: iempty forced high for 5 cycles after the 8th read -> rdreq low for 5 cycles; total reads=16; odone delayed by 5 cycles.
REQ-035 Mid-burst changes: ireq[0] drops after 3 reads while ireq[1] rises -> burst 0 completes all 16 reads; then grant to requester 1.
REQ-036 Reset mid-burst: ireset pulsed after 6 reads -> all outputs 0 asynchronously; no odone; next grant goes to the lowest active index.
